// File: rtl/maindec_pipe.sv
// maindec_pipe: registered main decoder at the ID/EX boundary.
// Decodes op/funct into the EX control word. It also issues MULT/MULTU/DIV/DIVU
// to the multi-cycle HI/LO unit, counts that unit's busy time, and holds any
// HI/LO consumer in ID until the unit is idle.
//
// Handshakes (strict valid/ready on both sides):
//   ID side : an instruction transfers in on a rising edge where id_valid && id_ready.
//             id_ready never depends on id_valid.
//   EX side : the control word is consumed on a rising edge where ex_valid && ex_ready.
//             While ex_valid && !ex_ready, every output is held stable.
module maindec_pipe #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 34,
    parameter bit EN_MULDIV  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        id_ready,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic        regwrite,
    output logic        regdst,
    output logic        alusrc,
    output logic        branch,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        jump,
    output logic [1:0]  hilowe,
    output logic [1:0]  hilochoose,
    output logic        muldiv_start,
    output logic        muldiv_signed,
    output logic        muldiv_isdiv,
    output logic        ri,
    output logic        hilo_busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    // Opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_J       = 6'b000010;
    localparam logic [5:0] EXE_BEQ     = 6'b000100;
    localparam logic [5:0] EXE_ADDI    = 6'b001000;
    localparam logic [5:0] EXE_ADDIU   = 6'b001001;
    localparam logic [5:0] EXE_SLTI    = 6'b001010;
    localparam logic [5:0] EXE_SLTIU   = 6'b001011;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_LB      = 6'b100000;
    localparam logic [5:0] EXE_LH      = 6'b100001;
    localparam logic [5:0] EXE_LW      = 6'b100011;
    localparam logic [5:0] EXE_LBU     = 6'b100100;
    localparam logic [5:0] EXE_LHU     = 6'b100101;
    localparam logic [5:0] EXE_SB      = 6'b101000;
    localparam logic [5:0] EXE_SH      = 6'b101001;
    localparam logic [5:0] EXE_SW      = 6'b101011;

    // SPECIAL functs
    localparam logic [5:0] EXE_SLL   = 6'b000000;
    localparam logic [5:0] EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA   = 6'b000011;
    localparam logic [5:0] EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV  = 6'b000110;
    localparam logic [5:0] EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_MFHI  = 6'b010000;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_ADD   = 6'b100000;
    localparam logic [5:0] EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB   = 6'b100010;
    localparam logic [5:0] EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_AND   = 6'b100100;
    localparam logic [5:0] EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR   = 6'b100110;
    localparam logic [5:0] EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLT   = 6'b101010;
    localparam logic [5:0] EXE_SLTU  = 6'b101011;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] hilowe;
        logic [1:0] hilochoose;
        logic       md_start;
        logic       md_signed;
        logic       md_isdiv;
        logic       ri;
    } ctrl_t;

    // Control words: {regwrite..jump, hilowe, hilochoose} then {start, signed, isdiv, ri}
    localparam ctrl_t W_RTYPE = ctrl_t'({11'b11000000000, 4'b0000});
    localparam ctrl_t W_MFHI  = ctrl_t'({11'b11000000011, 4'b0000});
    localparam ctrl_t W_MFLO  = ctrl_t'({11'b11000000001, 4'b0000});
    localparam ctrl_t W_MTHI  = ctrl_t'({11'b00000001011, 4'b0000});
    localparam ctrl_t W_MTLO  = ctrl_t'({11'b00000001001, 4'b0000});
    localparam ctrl_t W_MULT  = ctrl_t'({11'b00000001100, 4'b1100});
    localparam ctrl_t W_MULTU = ctrl_t'({11'b00000001100, 4'b1000});
    localparam ctrl_t W_DIV   = ctrl_t'({11'b00000001100, 4'b1110});
    localparam ctrl_t W_DIVU  = ctrl_t'({11'b00000001100, 4'b1010});
    localparam ctrl_t W_LOAD  = ctrl_t'({11'b10100100000, 4'b0000});
    localparam ctrl_t W_STORE = ctrl_t'({11'b00101000000, 4'b0000});
    localparam ctrl_t W_BEQ   = ctrl_t'({11'b00010000000, 4'b0000});
    localparam ctrl_t W_J     = ctrl_t'({11'b00000010000, 4'b0000});
    localparam ctrl_t W_IMM   = ctrl_t'({11'b10100000000, 4'b0000});
    localparam ctrl_t W_RI    = ctrl_t'({11'b00000000000, 4'b0001});

    logic [5:0]       op;
    logic [5:0]       funct;
    ctrl_t            dec;
    logic             hilo_use;
    logic             hazard;
    logic             xfer_in;
    logic             ex_hs;
    ctrl_t            word_q, word_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_bits;

    assign op          = id_instr[31:26];
    assign funct       = id_instr[5:0];
    assign unused_bits = ^id_instr[25:6];

    // Combinational decode of the instruction waiting in ID
    always_comb begin
        dec = W_RI;
        case (op)
            EXE_SPECIAL: begin
                case (funct)
                    EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
                    EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_AND, EXE_OR,
                    EXE_XOR, EXE_NOR, EXE_SLT, EXE_SLTU: dec = W_RTYPE;
                    EXE_MFHI:  dec = W_MFHI;
                    EXE_MFLO:  dec = W_MFLO;
                    EXE_MTHI:  dec = W_MTHI;
                    EXE_MTLO:  dec = W_MTLO;
                    EXE_MULT:  dec = EN_MULDIV ? W_MULT  : W_RI;
                    EXE_MULTU: dec = EN_MULDIV ? W_MULTU : W_RI;
                    EXE_DIV:   dec = EN_MULDIV ? W_DIV   : W_RI;
                    EXE_DIVU:  dec = EN_MULDIV ? W_DIVU  : W_RI;
                    default:   dec = W_RI;
                endcase
            end
            EXE_LW, EXE_LH, EXE_LHU, EXE_LB, EXE_LBU: dec = W_LOAD;
            EXE_SW, EXE_SH, EXE_SB:                   dec = W_STORE;
            EXE_BEQ:                                  dec = W_BEQ;
            EXE_J:                                    dec = W_J;
            EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
            EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI:     dec = W_IMM;
            default:                                  dec = W_RI;
        endcase
    end

    // Anything that reads or writes HI/LO must wait for the unit to be idle,
    // including an op issued from EX this very cycle.
    assign hilo_use  = dec.hilowe[1] | (|dec.hilochoose);
    assign hilo_busy = (cnt_q != '0);
    assign hazard    = hilo_use & (hilo_busy | (valid_q & word_q.md_start));
    assign id_ready  = (!valid_q || ex_ready) && !hazard && !flush;
    assign xfer_in   = id_valid && id_ready;
    assign ex_hs     = valid_q && ex_ready;

    // Output stage next state: flush kills, intake loads, consumption leaves a zero bubble
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (flush) begin
            word_d  = '0;
            valid_d = 1'b0;
        end else if (xfer_in) begin
            word_d  = dec;
            valid_d = 1'b1;
        end else if (ex_ready) begin
            word_d  = '0;
            valid_d = 1'b0;
        end
    end

    // Output stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    // Busy counter next state: an EX handshake of a muldiv op (even if flushed) starts it
    always_comb begin
        cnt_d = cnt_q;
        if (ex_hs && word_q.md_start) begin
            cnt_d = word_q.md_isdiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Busy counter register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign regwrite      = word_q.regwrite;
    assign regdst        = word_q.regdst;
    assign alusrc        = word_q.alusrc;
    assign branch        = word_q.branch;
    assign memwrite      = word_q.memwrite;
    assign memtoreg      = word_q.memtoreg;
    assign jump          = word_q.jump;
    assign hilowe        = word_q.hilowe;
    assign hilochoose    = word_q.hilochoose;
    assign muldiv_start  = word_q.md_start;
    assign muldiv_signed = word_q.md_signed;
    assign muldiv_isdiv  = word_q.md_isdiv;
    assign ri            = word_q.ri;

endmodule
